// File: rtl/stb_dcache_wr_responder.sv
// Data-cache side responder for store-buffer drains, sharing one memory port
// with LSU loads under a bounded-starvation arbitration rule.
module stb_dcache_wr_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LD_PRIORITY = 1,
    parameter int STARVE_MAX  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stb2dcache_req_i,
    input  logic [ADDR_W-1:0]   stb2dcache_addr_i,
    input  logic [DATA_W-1:0]   stb2dcache_wdata_i,
    input  logic [DATA_W/8-1:0] stb2dcache_sel_i,
    output logic                dcache2stb_ack_o,
    input  logic                lsu2dcache_ld_req_i,
    input  logic [ADDR_W-1:0]   lsu2dcache_addr_i,
    output logic [DATA_W-1:0]   dcache2lsu_rdata_o,
    output logic                dcache2lsu_ack_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic [CNT_W-1:0]    st_done_cnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_WR   = 3'd1,
        LD_RD   = 3'd2,
        ST_RESP = 3'd3,
        LD_RESP = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       st_grant;

    // A waiting store wins outright once loads have used up their allowance.
    assign st_grant = stb2dcache_req_i &&
                      (!lsu2dcache_ld_req_i || (LD_PRIORITY == 0) || (starve_cnt == STARVE_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            starve_cnt         <= '0;
            dcache2stb_ack_o   <= 1'b0;
            dcache2lsu_ack_o   <= 1'b0;
            dcache2lsu_rdata_o <= '0;
            mem_req_o          <= 1'b0;
            mem_we_o           <= 1'b0;
            mem_addr_o         <= '0;
            mem_wdata_o        <= '0;
            mem_sel_o          <= '0;
            st_done_cnt_o      <= '0;
        end else begin
            dcache2stb_ack_o <= 1'b0;
            dcache2lsu_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_grant) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= stb2dcache_addr_i;
                        mem_wdata_o <= stb2dcache_wdata_i;
                        mem_sel_o   <= stb2dcache_sel_i;
                        starve_cnt  <= '0;
                        state       <= ST_WR;
                    end else if (lsu2dcache_ld_req_i) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= lsu2dcache_addr_i;
                        mem_sel_o  <= '1;
                        starve_cnt <= stb2dcache_req_i ? starve_cnt + 4'd1 : '0;
                        state      <= LD_RD;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ST_WR: begin
                    if (mem_ack_i) begin
                        mem_req_o        <= 1'b0;
                        dcache2stb_ack_o <= 1'b1;
                        state            <= ST_RESP;
                    end
                end
                LD_RD: begin
                    if (mem_ack_i) begin
                        mem_req_o          <= 1'b0;
                        dcache2lsu_rdata_o <= mem_rdata_i;
                        dcache2lsu_ack_o   <= 1'b1;
                        state              <= LD_RESP;
                    end
                end
                ST_RESP: begin
                    if (st_done_cnt_o != '1) begin
                        st_done_cnt_o <= st_done_cnt_o + 1'b1;
                    end
                    state <= IDLE;
                end
                LD_RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stb_dcache_wr_responder.sv
// Directed bench for stb_dcache_wr_responder: store/load paths, arbitration,
// async reset and counter saturation, checked with immediate assertions.
module tb_stb_dcache_wr_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb2dcache_req_i;
    logic [31:0] stb2dcache_addr_i;
    logic [31:0] stb2dcache_wdata_i;
    logic [3:0]  stb2dcache_sel_i;
    logic        dcache2stb_ack_o;
    logic        lsu2dcache_ld_req_i;
    logic [31:0] lsu2dcache_addr_i;
    logic [31:0] dcache2lsu_rdata_o;
    logic        dcache2lsu_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [3:0]  st_done_cnt_o;
    logic        ack_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_ack_i = mem_req_o & ack_en;

    stb_dcache_wr_responder #(
        .ADDR_W(32), .DATA_W(32), .LD_PRIORITY(1), .STARVE_MAX(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stb2dcache_req_i(stb2dcache_req_i), .stb2dcache_addr_i(stb2dcache_addr_i),
        .stb2dcache_wdata_i(stb2dcache_wdata_i), .stb2dcache_sel_i(stb2dcache_sel_i),
        .dcache2stb_ack_o(dcache2stb_ack_o),
        .lsu2dcache_ld_req_i(lsu2dcache_ld_req_i), .lsu2dcache_addr_i(lsu2dcache_addr_i),
        .dcache2lsu_rdata_o(dcache2lsu_rdata_o), .dcache2lsu_ack_o(dcache2lsu_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .st_done_cnt_o(st_done_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ack_en = 1'b1;
        stb2dcache_req_i = 1'b0;
        stb2dcache_addr_i = '0;
        stb2dcache_wdata_i = '0;
        stb2dcache_sel_i = '0;
        lsu2dcache_ld_req_i = 1'b0;
        lsu2dcache_addr_i = '0;
        mem_rdata_i = '0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req_o), 0);
        check("rst_mem_we", 32'(mem_we_o), 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_sel", 32'(mem_sel_o), 0);
        check("rst_stb_ack", 32'(dcache2stb_ack_o), 0);
        check("rst_lsu_ack", 32'(dcache2lsu_ack_o), 0);
        check("rst_rdata", dcache2lsu_rdata_o, 0);
        check("rst_cnt", 32'(st_done_cnt_o), 0);
        rst_n = 1'b1;
        tick();

        // Single store, memory acks in the same cycle as the request
        stb2dcache_req_i = 1'b1;
        stb2dcache_addr_i = 32'h100;
        stb2dcache_wdata_i = 32'hDEADBEEF;
        stb2dcache_sel_i = 4'b0011;
        tick();
        check("st1_req", 32'(mem_req_o), 1);
        check("st1_we", 32'(mem_we_o), 1);
        check("st1_addr", mem_addr_o, 32'h100);
        check("st1_wdata", mem_wdata_o, 32'hDEADBEEF);
        check("st1_sel", 32'(mem_sel_o), 32'h3);
        check("st1_ack_early", 32'(dcache2stb_ack_o), 0);
        tick();
        check("st1_ack", 32'(dcache2stb_ack_o), 1);
        check("st1_req_drop", 32'(mem_req_o), 0);
        stb2dcache_req_i = 1'b0;
        tick();
        check("st1_ack_pulse", 32'(dcache2stb_ack_o), 0);
        check("st1_cnt", 32'(st_done_cnt_o), 1);

        // Store with 5-cycle memory delay; requester changes inputs mid-wait
        ack_en = 1'b0;
        stb2dcache_req_i = 1'b1;
        stb2dcache_addr_i = 32'h200;
        stb2dcache_wdata_i = 32'hCAFEF00D;
        stb2dcache_sel_i = 4'b1111;
        tick();
        stb2dcache_addr_i = 32'h999;
        stb2dcache_wdata_i = 32'h11111111;
        stb2dcache_sel_i = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) ack_en = 1'b1;
            check("st2_hold_req", 32'(mem_req_o), 1);
            check("st2_hold_addr", mem_addr_o, 32'h200);
            check("st2_hold_wdata", mem_wdata_o, 32'hCAFEF00D);
            check("st2_hold_sel", 32'(mem_sel_o), 32'hF);
            check("st2_no_ack", 32'(dcache2stb_ack_o), 0);
            if (i < 6) tick();
        end
        tick();
        check("st2_ack", 32'(dcache2stb_ack_o), 1);
        stb2dcache_req_i = 1'b0;
        tick();
        check("st2_cnt", 32'(st_done_cnt_o), 2);

        // Load path
        lsu2dcache_ld_req_i = 1'b1;
        lsu2dcache_addr_i = 32'h40;
        mem_rdata_i = 32'h12345678;
        tick();
        check("ld_req", 32'(mem_req_o), 1);
        check("ld_we", 32'(mem_we_o), 0);
        check("ld_sel", 32'(mem_sel_o), 32'hF);
        check("ld_addr", mem_addr_o, 32'h40);
        tick();
        check("ld_ack", 32'(dcache2lsu_ack_o), 1);
        check("ld_rdata", dcache2lsu_rdata_o, 32'h12345678);
        lsu2dcache_ld_req_i = 1'b0;
        mem_rdata_i = 32'h0;
        tick();
        check("ld_ack_pulse", 32'(dcache2lsu_ack_o), 0);
        check("ld_rdata_hold", dcache2lsu_rdata_o, 32'h12345678);
        tick();
        check("ld_rdata_hold2", dcache2lsu_rdata_o, 32'h12345678);

        // Arbitration: loads win twice, then the waiting store is forced through
        stb2dcache_req_i = 1'b1;
        stb2dcache_addr_i = 32'h300;
        stb2dcache_wdata_i = 32'h55AA55AA;
        stb2dcache_sel_i = 4'b1100;
        lsu2dcache_ld_req_i = 1'b1;
        lsu2dcache_addr_i = 32'h80;
        for (int g = 0; g < 2; g++) begin
            tick();
            check("arb_ld_grant_we", 32'(mem_we_o), 0);
            check("arb_ld_grant_addr", mem_addr_o, 32'h80);
            tick();
            check("arb_ld_ack", 32'(dcache2lsu_ack_o), 1);
            tick();
        end
        tick();
        check("arb_st_grant_we", 32'(mem_we_o), 1);
        check("arb_st_grant_addr", mem_addr_o, 32'h300);
        check("arb_st_grant_sel", 32'(mem_sel_o), 32'hC);
        check("arb_starve_clr", 32'(dut.starve_cnt), 0);
        tick();
        check("arb_st_ack", 32'(dcache2stb_ack_o), 1);
        stb2dcache_req_i = 1'b0;
        lsu2dcache_ld_req_i = 1'b0;
        tick();
        check("arb_cnt", 32'(st_done_cnt_o), 3);

        // Asynchronous reset while the store is waiting on memory
        ack_en = 1'b0;
        stb2dcache_req_i = 1'b1;
        tick();
        check("rst_mid_req_before", 32'(mem_req_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_async", 32'(mem_req_o), 0);
        stb2dcache_req_i = 1'b0;
        ack_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_mid_no_ack", 32'(dcache2stb_ack_o), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_post_no_ack", 32'(dcache2stb_ack_o), 0);
            check("rst_post_req", 32'(mem_req_o), 0);
        end
        check("rst_post_cnt", 32'(st_done_cnt_o), 0);
        check("rst_post_state", 32'(dut.state), 0);

        // 17 stores saturate the 4-bit counter at 15
        for (int n = 1; n <= 17; n++) begin
            stb2dcache_req_i = 1'b1;
            stb2dcache_addr_i = 32'(n);
            tick();
            tick();
            check("sat_ack", 32'(dcache2stb_ack_o), 1);
            stb2dcache_req_i = 1'b0;
            tick();
            check("sat_cnt", 32'(st_done_cnt_o), (n > 15) ? 32'd15 : 32'(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stb_dcache_wr_responder.md
Name: stb_dcache_wr_responder

Overview:
Responder at the data-cache end of the store-buffer drain interface. It accepts one buffered store at a time from the store buffer and performs it on the single-ported data memory port. When the store completes it returns a one-cycle `dcache2stb_ack_o` pulse. It also arbitrates that memory port between store-buffer drains and LSU loads, with a bounded-starvation rule so stores always make progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- LD_PRIORITY, 1, 1 = loads win simultaneous requests, 0 = stores win.
- STARVE_MAX, 4, maximum consecutive load grants while a store waits; range 1..15.
- CNT_W, 16, width of the completed-store counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stb2dcache_req_i  in  1  store request; level, held until ack
- stb2dcache_addr_i  in  ADDR_W  store address
- stb2dcache_wdata_i  in  DATA_W  store data
- stb2dcache_sel_i  in  DATA_W/8  byte enables
- dcache2stb_ack_o  out  1  one-cycle store-complete pulse
- lsu2dcache_ld_req_i  in  1  load request; level, held until ack
- lsu2dcache_addr_i  in  ADDR_W  load address
- dcache2lsu_rdata_o  out  DATA_W  load data, valid with ack
- dcache2lsu_ack_o  out  1  one-cycle load-complete pulse
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_sel_o  out  DATA_W/8  registered byte enables; all ones for reads
- mem_ack_i  in  1  memory completion
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- st_done_cnt_o  out  CNT_W  saturating count of completed stores

Behaviour:
- Reset values: state IDLE; every output 0; starvation counter 0; `st_done_cnt_o` 0.
- Reset mid-operation: `mem_req_o` drops immediately (asynchronous), any captured request is discarded, no ack is issued.
- States:
  - IDLE: arbitrate and capture the request.
  - ST_WR: `mem_req_o`=1, `mem_we_o`=1.
  - LD_RD: `mem_req_o`=1, `mem_we_o`=0.
  - ST_RESP: `dcache2stb_ack_o`=1.
  - LD_RESP: `dcache2lsu_ack_o`=1.
- IDLE arbitration:
  - Only the store request is high: capture store address, data and sel into the mem_* registers; go to ST_WR.
  - Only the load request is high: capture load address, set `mem_sel_o` to all ones; go to LD_RD.
  - Both high:
    - Store wins if LD_PRIORITY=0, or if the starvation counter equals STARVE_MAX.
    - Otherwise load wins.
  - Starvation counter:
    - Increments on each load grant made while `stb2dcache_req_i`=1.
    - Clears on every store grant.
    - Clears in any IDLE cycle where `stb2dcache_req_i`=0.
  - Neither high: stay in IDLE.
- ST_WR / LD_RD: hold all mem_* outputs stable until `mem_ack_i`=1, then go to ST_RESP / LD_RESP. `mem_ack_i` while in IDLE or a RESP state is ignored.
- LD_RD completion: register `mem_rdata_i` into `dcache2lsu_rdata_o` on the `mem_ack_i` edge. The value is held until the next load completes.
- RESP states:
  - Ack is a single-cycle pulse, then return to IDLE unconditionally.
  - No request is accepted during a RESP cycle; the requester drops or advances its request on the ack edge.
  - ST_RESP also increments `st_done_cnt_o`, saturating at all ones.
- `mem_req_o` deasserts in the RESP cycle.
- Latency: request first seen in IDLE at cycle T → `mem_req_o` at T+1 → `mem_ack_i` at T+1+k (k≥0) → ack pulse at T+2+k. Minimum request-to-ack is 2 cycles; minimum spacing between back-to-back acks is 3 cycles.
- Changes to request inputs after capture have no effect until the next IDLE.
- No address comparison is done between loads and stores; ordering is the store buffer's responsibility.

Test Plan:
- Single store, addr 0x100, wdata 0xDEADBEEF, sel 4'b0011, memory acks in the same cycle as `mem_req_o` → `mem_req_o`/`mem_we_o` high at T+1 with those exact values; `dcache2stb_ack_o` single pulse at T+2; `st_done_cnt_o`=1.
- Store with memory ack delayed 5 cycles, stb changes addr/data mid-wait → mem_* outputs stay constant throughout; ack at T+7.
- Simultaneous load and store, LD_PRIORITY=1, STARVE_MAX=2, load request held high with back-to-back loads → grant order: load, load, store; starvation counter back to 0 after the store grant.
- Load from addr 0x40, `mem_rdata_i`=0x12345678 → `mem_we_o`=0, `mem_sel_o`=all ones; `dcache2lsu_ack_o` pulse with `dcache2lsu_rdata_o`=0x12345678, data held afterwards.
- Assert rst_n low while in ST_WR → `mem_req_o`=0 asynchronously; no ack at any point; after release, state is IDLE and the counter is 0.
- CNT_W=4, 17 stores → `st_done_cnt_o` saturates at 15.
